// File: rtl/uart_wb_pkg.sv
// Shared definitions for the uart Wishbone master: register map, bus
// direction encoding, controller states and the bus command record.
// No logic lives here; the register map mirrors the uart slave.
package uart_wb_pkg;

   // uart slave register map
   localparam logic [1:0] ADDR_TX  = 2'b00;
   localparam logic [1:0] ADDR_RX  = 2'b01;
   localparam logic [1:0] ADDR_DIV = 2'b10;

   // bus direction: this bus uses 0 for write, 1 for read
   localparam logic WE_WRITE = 1'b0;
   localparam logic WE_READ  = 1'b1;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_IDLE    = 2'd1,
      ST_REQ     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   // one bus transaction as presented to the slave
   typedef struct packed {
      logic [1:0] addr;
      logic       we;
      logic [7:0] data;
   } cmd_t;

endpackage

// File: rtl/uart_wb_master.sv
// Purpose: Wishbone master that turns divider config, TX bytes and RX read strobes into uart register accesses.
// Latency: request seen in IDLE -> wb_stb on the next edge; ack -> RELEASE -> IDLE once ack is sampled low.
// Backpressure: tx_ready drops outside IDLE or while config/TX work is queued; cfg/rx strobes are held as sticky pending flags.
module uart_wb_master #(
   parameter logic [7:0] DEFAULT_DIV = 8'd12,
   parameter int          ACK_TIMEOUT = 32
) (
   input  logic       wb_clk,
   input  logic       reset,
   input  logic [7:0] cfg_div,
   input  logic       cfg_load,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       rx_req,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       timeout_err,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data_out,
   input  logic [7:0] wb_data_in,
   output logic       wb_we,
   output logic       wb_stb,
   input  logic       wb_ack
);

   import uart_wb_pkg::*;

   // last counter value still inside the ack window; the abort happens on the edge that sees it
   localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

   state_t     state_q, state_d;
   cmd_t       cmd_q, cmd_d;
   logic       stb_q, stb_d;
   logic       cfg_pend_q, cfg_pend_d;
   logic [7:0] cfg_val_q, cfg_val_d;
   logic       tx_pend_q, tx_pend_d;
   logic [7:0] tx_buf_q, tx_buf_d;
   logic       rx_pend_q, rx_pend_d;
   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tmo_err_q, tmo_err_d;
   logic       tx_ready_q, tx_ready_d;
   logic       busy_q, busy_d;
   logic       start;

   assign wb_addr     = cmd_q.addr;
   assign wb_we       = cmd_q.we;
   assign wb_data_out = cmd_q.data;
   assign wb_stb      = stb_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign timeout_err = tmo_err_q;
   assign tx_ready    = tx_ready_q;
   assign busy        = busy_q;

   // Next-state logic: capture strobes, arbitrate in IDLE, run the bus handshake and timeout.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      stb_d       = stb_q;
      cfg_pend_d  = cfg_pend_q;
      cfg_val_d   = cfg_val_q;
      tx_pend_d   = tx_pend_q;
      tx_buf_d    = tx_buf_q;
      rx_pend_d   = rx_pend_q;
      tmo_cnt_d   = tmo_cnt_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tmo_err_d   = 1'b0;
      start       = 1'b0;

      // strobes are sticky in every state; a repeat overwrites the divider or is absorbed
      if (cfg_load) begin
         cfg_pend_d = 1'b1;
         cfg_val_d  = cfg_div;
      end
      if (rx_req) begin
         rx_pend_d = 1'b1;
      end
      // an accepted byte is parked so a same-cycle config write can still go first
      if (tx_valid && tx_ready_q) begin
         tx_pend_d = 1'b1;
         tx_buf_d  = tx_data;
      end

      unique case (state_q)
         ST_INIT: begin
            // wait out any ack still held from a transaction cut short by reset
            if (!wb_ack) begin
               cmd_d = '{addr: ADDR_DIV, we: WE_WRITE, data: DEFAULT_DIV};
               start = 1'b1;
            end
         end
         ST_IDLE: begin
            // a spurious ack blocks new work until it has been seen low
            if (!wb_ack) begin
               if (cfg_pend_d) begin
                  cmd_d      = '{addr: ADDR_DIV, we: WE_WRITE, data: cfg_val_d};
                  cfg_pend_d = 1'b0;
                  start      = 1'b1;
               end else if (tx_pend_d) begin
                  cmd_d     = '{addr: ADDR_TX, we: WE_WRITE, data: tx_buf_d};
                  tx_pend_d = 1'b0;
                  start     = 1'b1;
               end else if (rx_pend_d) begin
                  cmd_d     = '{addr: ADDR_RX, we: WE_READ, data: 8'h00};
                  rx_pend_d = 1'b0;
                  start     = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (wb_ack) begin
               stb_d   = 1'b0;
               state_d = ST_RELEASE;
               if (cmd_q.we == WE_READ) begin
                  rx_data_d  = wb_data_in;
                  rx_valid_d = 1'b1;
               end
            end else if (tmo_cnt_q >= TMO_LAST) begin
               stb_d     = 1'b0;
               tmo_err_d = 1'b1;
               state_d   = ST_RELEASE;
            end else if (tmo_cnt_q != 8'hFF) begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end
         ST_RELEASE: begin
            if (!wb_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      if (start) begin
         stb_d     = 1'b1;
         tmo_cnt_d = 8'd0;
         state_d   = ST_REQ;
      end

      tx_ready_d = (state_d == ST_IDLE) && !cfg_pend_d && !tx_pend_d;
      busy_d     = (state_d != ST_IDLE) || cfg_pend_d || tx_pend_d || rx_pend_d;
   end

   // State and output registers; reset discards any in-flight or pending work.
   always_ff @(posedge wb_clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         cmd_q      <= '{addr: 2'b00, we: WE_READ, data: 8'h00};
         stb_q      <= 1'b0;
         cfg_pend_q <= 1'b0;
         cfg_val_q  <= 8'h00;
         tx_pend_q  <= 1'b0;
         tx_buf_q   <= 8'h00;
         rx_pend_q  <= 1'b0;
         tmo_cnt_q  <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tmo_err_q  <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         stb_q      <= stb_d;
         cfg_pend_q <= cfg_pend_d;
         cfg_val_q  <= cfg_val_d;
         tx_pend_q  <= tx_pend_d;
         tx_buf_q   <= tx_buf_d;
         rx_pend_q  <= rx_pend_d;
         tmo_cnt_q  <= tmo_cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tmo_err_q  <= tmo_err_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: a behavioural uart register slave logs every
// accepted bus access; expected access lists come from the request order
// rules (cfg before tx before rx) and are compared after each burst.
module tb_uart_wb_master;

   localparam int K_CFG = 0;
   localparam int K_TX  = 1;
   localparam int K_RX  = 2;

   logic       wb_clk = 1'b0;
   logic       reset;
   logic [7:0] cfg_div;
   logic       cfg_load;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       rx_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       timeout_err;
   logic [1:0] wb_addr;
   logic [7:0] wb_data_out;
   logic [7:0] wb_data_in;
   logic       wb_we;
   logic       wb_stb;
   logic       wb_ack = 1'b0;

   always #5 wb_clk = ~wb_clk;

   uart_wb_master #(.DEFAULT_DIV(8'd12), .ACK_TIMEOUT(32)) dut (
      .wb_clk(wb_clk), .reset(reset),
      .cfg_div(cfg_div), .cfg_load(cfg_load),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_req(rx_req), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .timeout_err(timeout_err),
      .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
      .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack)
   );

   typedef struct {
      logic [1:0] addr;
      logic       we;
      logic [7:0] data;
   } txn_t;

   txn_t log_q[$];
   txn_t exp_q[$];

   // slave model: ack after slave_delay cycles of stb, hold ack until stb seen low
   logic       slave_mute = 1'b0;
   int         slave_delay = 0;
   logic [7:0] slave_rx = 8'h00;
   logic [7:0] rd_q = 8'h00;
   int         dly_cnt = 0;
   txn_t       seen;

   always @(posedge wb_clk) begin
      if (!wb_stb) begin
         wb_ack  <= 1'b0;
         dly_cnt <= 0;
      end else if (!wb_ack && !slave_mute) begin
         if (dly_cnt >= slave_delay) begin
            wb_ack    <= 1'b1;
            rd_q      <= slave_rx;
            seen.addr = wb_addr;
            seen.we   = wb_we;
            seen.data = wb_data_out;
            log_q.push_back(seen);
         end else begin
            dly_cnt <= dly_cnt + 1;
         end
      end
   end

   assign wb_data_in = wb_ack ? rd_q : 8'h00;

   // cycle counters for pulse-width and strobe-length checks
   int stb_cyc = 0, rxv_cyc = 0, tmo_cyc = 0;
   always @(posedge wb_clk) begin
      #1;
      if (wb_stb)      stb_cyc++;
      if (rx_valid)    rxv_cyc++;
      if (timeout_err) tmo_cyc++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic clear_counts();
      stb_cyc = 0; rxv_cyc = 0; tmo_cyc = 0;
      log_q.delete();
      exp_q.delete();
   endtask

   task automatic expect_txn(input logic [1:0] a, input logic w, input logic [7:0] d);
      txn_t t;
      t.addr = a; t.we = w; t.data = d;
      exp_q.push_back(t);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge wb_clk);
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic check_log(input string tag);
      check({tag, ".count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s.addr[%0d]", tag, i), log_q[i].addr, exp_q[i].addr);
         check($sformatf("%s.we[%0d]", tag, i), log_q[i].we, exp_q[i].we);
         if (exp_q[i].we == 1'b0)
            check($sformatf("%s.data[%0d]", tag, i), log_q[i].data, exp_q[i].data);
      end
   endtask

   // caller is at a negedge; strobes last exactly one clock
   task automatic issue(input bit c, input bit t, input bit r, input logic [7:0] cd, input logic [7:0] td);
      cfg_load = c; cfg_div = cd;
      tx_valid = t; tx_data = td;
      rx_req   = r;
      @(negedge wb_clk);
      cfg_load = 1'b0; tx_valid = 1'b0; rx_req = 1'b0;
   endtask

   typedef struct {
      int         kind;
      logic [7:0] dat;
      logic [7:0] sval;
      logic [1:0] eaddr;
      logic       ewe;
   } vec_t;

   vec_t vecs[6];
   logic [7:0] rx_hold;

   initial begin
      vecs[0] = '{K_TX,  8'h55, 8'h00, 2'b00, 1'b0};
      vecs[1] = '{K_RX,  8'h00, 8'hA7, 2'b01, 1'b1};
      vecs[2] = '{K_CFG, 8'h03, 8'h00, 2'b10, 1'b0};
      vecs[3] = '{K_TX,  8'hFF, 8'h00, 2'b00, 1'b0};
      vecs[4] = '{K_RX,  8'h00, 8'h3C, 2'b01, 1'b1};
      vecs[5] = '{K_CFG, 8'h00, 8'h00, 2'b10, 1'b0};

      reset = 1'b1; cfg_div = 8'h00; cfg_load = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_req = 1'b0;
      rx_hold = 8'h00;
      repeat (3) @(negedge wb_clk);

      // reset values
      check("rst.wb_stb", wb_stb, 1'b0);
      check("rst.wb_we", wb_we, 1'b1);
      check("rst.wb_addr", wb_addr, 2'b00);
      check("rst.wb_data_out", wb_data_out, 8'h00);
      check("rst.rx_data", rx_data, 8'h00);
      check("rst.rx_valid", rx_valid, 1'b0);
      check("rst.tx_ready", tx_ready, 1'b0);
      check("rst.timeout_err", timeout_err, 1'b0);
      check("rst.busy", busy, 1'b1);

      // automatic divider write after reset
      clear_counts();
      reset = 1'b0;
      expect_txn(2'b10, 1'b0, 8'd12);
      @(negedge wb_clk);
      wait_idle(50);
      check_log("init");
      check("init.tx_ready", tx_ready, 1'b1);
      check("init.busy", busy, 1'b0);

      // single requests from the table
      foreach (vecs[i]) begin
         clear_counts();
         slave_rx = vecs[i].sval;
         expect_txn(vecs[i].eaddr, vecs[i].ewe, vecs[i].dat);
         issue(vecs[i].kind == K_CFG, vecs[i].kind == K_TX, vecs[i].kind == K_RX, vecs[i].dat, vecs[i].dat);
         if (vecs[i].kind == K_TX)
            check($sformatf("vec%0d.tx_ready_busy", i), tx_ready, 1'b0);
         wait_idle(50);
         check_log($sformatf("vec%0d", i));
         if (vecs[i].kind == K_RX) rx_hold = vecs[i].sval;
         check($sformatf("vec%0d.rx_data", i), rx_data, rx_hold);
         check($sformatf("vec%0d.rx_valid_cycles", i), rxv_cyc, (vecs[i].kind == K_RX) ? 1 : 0);
      end

      // three requests in one cycle: cfg, then tx, then rx
      clear_counts();
      slave_rx = 8'h6E;
      expect_txn(2'b10, 1'b0, 8'h03);
      expect_txn(2'b00, 1'b0, 8'h41);
      expect_txn(2'b01, 1'b1, 8'h00);
      issue(1'b1, 1'b1, 1'b1, 8'h03, 8'h41);
      wait_idle(100);
      check_log("trio");
      rx_hold = 8'h6E;
      check("trio.rx_data", rx_data, rx_hold);
      check("trio.rx_valid_cycles", rxv_cyc, 1);

      // ack timeout on a read: 32 strobe cycles, one error pulse, no data
      clear_counts();
      slave_mute = 1'b1;
      slave_rx = 8'hEE;
      issue(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      wait_idle(100);
      check("tmo.stb_cycles", stb_cyc, 32);
      check("tmo.err_cycles", tmo_cyc, 1);
      check("tmo.rx_valid_cycles", rxv_cyc, 0);
      check("tmo.rx_data", rx_data, rx_hold);
      check_log("tmo");
      slave_mute = 1'b0;
      clear_counts();
      expect_txn(2'b00, 1'b0, 8'h99);
      issue(1'b0, 1'b1, 1'b0, 8'h00, 8'h99);
      wait_idle(50);
      check_log("after_tmo");

      // reset while strobing; init write reissues, cfg arriving in INIT follows it
      clear_counts();
      slave_delay = 5;
      issue(1'b0, 1'b1, 1'b0, 8'h00, 8'h77);
      check("mid.stb_high", wb_stb, 1'b1);
      reset = 1'b1;
      @(negedge wb_clk);
      check("mid.stb_dropped", wb_stb, 1'b0);
      @(negedge wb_clk);
      slave_delay = 0;
      expect_txn(2'b10, 1'b0, 8'd12);
      expect_txn(2'b10, 1'b0, 8'h21);
      reset = 1'b0;
      issue(1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
      wait_idle(100);
      check_log("reinit");

      // random bursts against the ordering model
      for (int it = 0; it < 40; it++) begin
         int         mask;
         logic [7:0] cd, td;
         clear_counts();
         mask        = int'($urandom_range(1, 7));
         cd          = 8'($urandom);
         td          = 8'($urandom);
         slave_rx    = 8'($urandom);
         slave_delay = int'($urandom_range(0, 3));
         if (mask[0]) expect_txn(2'b10, 1'b0, cd);
         if (mask[1]) expect_txn(2'b00, 1'b0, td);
         if (mask[2]) expect_txn(2'b01, 1'b1, 8'h00);
         issue(mask[0], mask[1], mask[2], cd, td);
         wait_idle(150);
         check_log($sformatf("rnd%0d", it));
         if (mask[2]) rx_hold = slave_rx;
         check($sformatf("rnd%0d.rx_data", it), rx_data, rx_hold);
         check($sformatf("rnd%0d.rx_valid_cycles", it), rxv_cyc, mask[2] ? 1 : 0);
         check($sformatf("rnd%0d.tmo_cycles", it), tmo_cyc, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
